sm_gpio_debounce: RTL and testbench
===================================

# sm_gpio_debounce

Input-conditioning stage for the external GPIO switches and buttons on the DE0-CV board. It takes the raw, asynchronous `GPIO_0[8:1]` pins, synchronizes and debounces each bit, and produces a clean level vector plus per-bit rise/fall pulses. The level vector is the `gpioInput` source for `sm_top` on the board top; the pulses are available for interrupt or event logic. Each bit is conditioned independently.

## Interface
- `WIDTH`, 8: number of conditioned input bits.
- `STABLE_CYCLES`, 50000: consecutive cycles a synchronized bit must hold a new value before it is accepted. 1 ms at 50 MHz. Legal range 2 to 2^`CNT_WIDTH`.
- `CNT_WIDTH`, 16: per-bit stability counter width.

- `clk`, input, 1: system clock, `CLOCK_50` domain.
- `rst_n`, input, 1: asynchronous active-low reset.
- `gpio_raw`, input, `WIDTH`: raw pin levels, asynchronous to `clk`.
- `gpio_out`, output, `WIDTH`: debounced levels, registered.
- `gpio_rise`, output, `WIDTH`: one-cycle pulse per bit when `gpio_out` goes 0→1.
- `gpio_fall`, output, `WIDTH`: one-cycle pulse per bit when `gpio_out` goes 1→0.
- `gpio_change`, output, 1: one-cycle pulse, equal to the OR-reduction of (`gpio_rise | gpio_fall`), registered.

## Operation
- **Synchronizer:** per bit, a two-flop chain `s1 <= gpio_raw`, `s2 <= s1`. No logic sits between the two flops.
- **Stability counter:** per bit, compared against `s2` on every cycle.
  - `s2 == gpio_out[i]`: counter is cleared to 0.
  - `s2 != gpio_out[i]` and counter < `STABLE_CYCLES-1`: counter increments.
  - `s2 != gpio_out[i]` and counter == `STABLE_CYCLES-1`: `gpio_out[i] <= s2`, counter cleared, and the matching rise or fall bit is set for exactly one cycle.
- **Glitches:** a level that returns to the `gpio_out` value before the count completes clears the counter. No output change and no pulse occur.
- **Counter width:** the counter never exceeds `STABLE_CYCLES-1` and never wraps.
- **Independence:** bits are fully independent. Simultaneous accepts on several bits in the same cycle assert all of the corresponding pulses in that same cycle. `gpio_change` is asserted once for that cycle.
- **Mutual exclusion:** `gpio_rise[i]` and `gpio_fall[i]` are never high together.

## Timing
- **Reset values:** all of `s1`, `s2`, counters, `gpio_out`, `gpio_rise`, `gpio_fall` and `gpio_change` are 0 while `rst_n` is low.
- **Reset mid-count:** asserting reset mid-count discards the partial count. After release, a pin already held high is accepted as a normal rise with full latency; there is no silent preload.
- **Latency:** if `gpio_raw[i]` changes before edge t and then stays stable:
  - `s2` takes the new value after edge t+1.
  - `gpio_out[i]` updates after edge t+1+`STABLE_CYCLES`.
  - Total latency is `STABLE_CYCLES`+2 edges.
- **Pulse alignment:** `gpio_rise`, `gpio_fall` and `gpio_change` are high in the same cycle that `gpio_out` first shows the new value, and low in the following cycle.
- **Minimum accepted pulse:** a raw pulse shorter than `STABLE_CYCLES` cycles (as seen at `s2`) is rejected. A pulse of exactly `STABLE_CYCLES` cycles is accepted.
- **Throughput:** back-to-back accepted transitions on one bit are separated by at least `STABLE_CYCLES` cycles.

## Structure
- **Shared definitions:** `SM_GPIO_WIDTH` and the default debounce length `SM_GPIO_DEBOUNCE` are defined in `sm_config.vh`. The board top passes `WIDTH` = 8, the physical pin count, and zero-extends `gpio_out` to `SM_GPIO_WIDTH`.
- **Sub-module:** `sm_debounce_bit` contains the synchronizer, counter, level register and rise/fall registers for one bit. The top generates `WIDTH` instances and registers the OR-reduction for `gpio_change`.
- **Board top changes:** `gpioInput` becomes `{8'b0, gpio_out}`, replacing the raw `GPIO_0[8:1]`.

## Test plan
All scenarios run with `STABLE_CYCLES` = 4 and `WIDTH` = 8.
- **Reset:** hold `rst_n` low with `gpio_raw` = 8'hFF → all outputs are 0. Release → `gpio_out` = 8'hFF exactly 6 edges later, `gpio_rise` = 8'hFF for one cycle, `gpio_change` = 1 for one cycle.
- **Glitch rejection:** `gpio_out` = 0. Drive bit 3 high for 3 cycles, then low → `gpio_out` stays 0 and no pulses occur. Drive bit 3 high for 4 cycles → `gpio_out[3]` = 1 at edge t+6 and `gpio_rise` = 8'h08 for one cycle.
- **Bounce:** bit 0 toggles 1,0,1,0,1 on single cycles, then holds 1 → exactly one rise pulse, 6 edges after the final stable 1.
- **Fall:** `gpio_out` = 8'h81. Drop bit 7 → `gpio_out` = 8'h01, `gpio_fall` = 8'h80 for one cycle, `gpio_rise` = 0.
- **Simultaneous:** bits 1 and 2 rise in the same cycle while bit 5 falls → `gpio_rise` = 8'h06 and `gpio_fall` = 8'h20 in the same single cycle, `gpio_change` = 1 for one cycle.
- **Reset mid-count:** bit 4 high for 2 cycles, then pulse `rst_n` low for 1 cycle with bit 4 still high → `gpio_out[4]` rises a full 6 edges after reset release, never earlier.

Source files
------------

// File: rtl/sm_gpio_debounce_pkg.sv
// Shared defaults and edge-pulse type for the GPIO input-conditioning stage.
`default_nettype none

package sm_gpio_debounce_pkg;

  localparam int SM_GPIO_WIDTH_DEF     = 8;
  localparam int SM_GPIO_DEBOUNCE_DEF  = 50000;
  localparam int SM_GPIO_CNT_WIDTH_DEF = 16;

  typedef struct packed {
    logic rise;
    logic fall;
  } sm_edge_t;

  // Direction of an accepted transition follows the level being accepted.
  function automatic sm_edge_t edge_of(input logic accept, input logic new_level);
    sm_edge_t e;
    e.rise = accept & new_level;
    e.fall = accept & ~new_level;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sm_debounce_bit.sv
// One conditioned GPIO bit: 2-flop synchronizer, stability counter,
// debounced level and rise/fall pulse registers.
`default_nettype none

module sm_debounce_bit
  import sm_gpio_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = SM_GPIO_DEBOUNCE_DEF,
  parameter int CNT_WIDTH     = SM_GPIO_CNT_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 s1;
  logic                 s2;
  logic [CNT_WIDTH-1:0] cnt;
  sm_edge_t             edge_q;

  // Exposed combinationally so the top can register gpio_change in the
  // same cycle that level and the pulses update.
  assign accept = (s2 != level) && (cnt == LAST);
  assign rise   = edge_q.rise;
  assign fall   = edge_q.fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      edge_q <= '0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      edge_q <= edge_of(accept, s2);
      if (s2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        cnt   <= '0;
        level <= s2;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sm_gpio_debounce.sv
// Debounces WIDTH asynchronous GPIO pins into clean levels plus per-bit
// rise/fall pulses and a combined change pulse.
`default_nettype none

module sm_gpio_debounce
  import sm_gpio_debounce_pkg::*;
#(
  parameter int WIDTH         = SM_GPIO_WIDTH_DEF,
  parameter int STABLE_CYCLES = SM_GPIO_DEBOUNCE_DEF,
  parameter int CNT_WIDTH     = SM_GPIO_CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_raw,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_rise,
  output logic [WIDTH-1:0] gpio_fall,
  output logic             gpio_change
);

  logic [WIDTH-1:0] accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sm_debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_WIDTH    (CNT_WIDTH)
    ) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (gpio_raw[i]),
      .level (gpio_out[i]),
      .rise  (gpio_rise[i]),
      .fall  (gpio_fall[i]),
      .accept(accept[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_change <= 1'b0;
    end else begin
      gpio_change <= |accept;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sm_gpio_debounce.sv
// Self-checking bench for sm_gpio_debounce with STABLE_CYCLES = 4, WIDTH = 8.
`default_nettype none

module tb_sm_gpio_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] gpio_raw;
  logic [7:0] gpio_out;
  logic [7:0] gpio_rise;
  logic [7:0] gpio_fall;
  logic       gpio_change;

  always #5 clk = ~clk;

  sm_gpio_debounce #(
    .WIDTH        (8),
    .STABLE_CYCLES(4),
    .CNT_WIDTH    (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gpio_raw   (gpio_raw),
    .gpio_out   (gpio_out),
    .gpio_rise  (gpio_rise),
    .gpio_fall  (gpio_fall),
    .gpio_change(gpio_change)
  );

  typedef struct {
    logic       rst_n;
    logic [7:0] raw;
    logic [7:0] out;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       chg;
  } vec_t;

  typedef struct {
    logic [7:0] out;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       chg;
    int         step;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;
  int   step_n = 0;

  task automatic add(input logic r, input logic [7:0] raw, input logic [7:0] out,
                     input logic [7:0] rise, input logic [7:0] fall, input logic chg,
                     input int n = 1);
    vec_t v;
    v.rst_n = r; v.raw = raw; v.out = out; v.rise = rise; v.fall = fall; v.chg = chg;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check_one();
    exp_t e;
    tests++;
    if (exp_q.size() == 0) begin
      failed++;
      $display("FAIL scoreboard_empty: actual queue size 0, required >0");
      return;
    end
    e = exp_q.pop_front();
    if (gpio_out !== e.out || gpio_rise !== e.rise || gpio_fall !== e.fall ||
        gpio_change !== e.chg || (gpio_rise & gpio_fall) != 8'h00) begin
      failed++;
      $display("FAIL step%0d: actual out=%h rise=%h fall=%h chg=%b, required out=%h rise=%h fall=%h chg=%b",
               e.step, gpio_out, gpio_rise, gpio_fall, gpio_change,
               e.out, e.rise, e.fall, e.chg);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    step_n++;
    rst_n    = v.rst_n;
    gpio_raw = v.raw;
    e.out = v.out; e.rise = v.rise; e.fall = v.fall; e.chg = v.chg; e.step = step_n;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_one();
  endtask

  task automatic drive(input logic r, input logic [7:0] raw, input logic [7:0] out,
                       input logic [7:0] rise, input logic [7:0] fall, input logic chg,
                       input int n = 1);
    vec_t v;
    v.rst_n = r; v.raw = raw; v.out = out; v.rise = rise; v.fall = fall; v.chg = chg;
    for (int k = 0; k < n; k++) step(v);
  endtask

  initial begin
    rst_n    = 1'b0;
    gpio_raw = 8'hFF;

    // Reset with pins high, then release: accepted 6 edges later.
    add(0, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 3);
    add(1, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 5);
    add(1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1);
    add(1, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 2);
    // All bits fall.
    add(1, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 5);
    add(1, 8'h00, 8'h00, 8'h00, 8'hFF, 1);
    add(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2);
    // Bit 3 high for 3 cycles: rejected.
    add(1, 8'h08, 8'h00, 8'h00, 8'h00, 0, 3);
    add(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 6);
    // Bit 3 high for exactly 4 cycles: accepted, then falls again.
    add(1, 8'h08, 8'h00, 8'h00, 8'h00, 0, 4);
    add(1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(1, 8'h00, 8'h08, 8'h08, 8'h00, 1);
    add(1, 8'h00, 8'h08, 8'h00, 8'h00, 0, 3);
    add(1, 8'h00, 8'h00, 8'h00, 8'h08, 1);
    add(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2);
    // Bounce on bit 0, then hold high: single rise 6 edges after final 1.
    add(1, 8'h01, 8'h00, 8'h00, 8'h00, 0);
    add(1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(1, 8'h01, 8'h00, 8'h00, 8'h00, 0);
    add(1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(1, 8'h01, 8'h00, 8'h00, 8'h00, 0, 5);
    add(1, 8'h01, 8'h01, 8'h01, 8'h00, 1);
    add(1, 8'h01, 8'h01, 8'h00, 8'h00, 0, 2);
    // Reach 8'h81, then drop bit 7.
    add(1, 8'h81, 8'h01, 8'h00, 8'h00, 0, 5);
    add(1, 8'h81, 8'h81, 8'h80, 8'h00, 1);
    add(1, 8'h81, 8'h81, 8'h00, 8'h00, 0);
    add(1, 8'h01, 8'h81, 8'h00, 8'h00, 0, 5);
    add(1, 8'h01, 8'h01, 8'h00, 8'h80, 1);
    add(1, 8'h01, 8'h01, 8'h00, 8'h00, 0);
    // Bit 5 up, then bits 1,2 rise while bit 5 falls in the same cycle.
    add(1, 8'h21, 8'h01, 8'h00, 8'h00, 0, 5);
    add(1, 8'h21, 8'h21, 8'h20, 8'h00, 1);
    add(1, 8'h21, 8'h21, 8'h00, 8'h00, 0);
    add(1, 8'h07, 8'h21, 8'h00, 8'h00, 0, 5);
    add(1, 8'h07, 8'h07, 8'h06, 8'h20, 1);
    add(1, 8'h07, 8'h07, 8'h00, 8'h00, 0, 2);

    foreach (vecs[i]) step(vecs[i]);

    // Reset mid-count: partial count on bit 4 must be discarded.
    drive(0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    drive(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2);
    drive(1, 8'h10, 8'h00, 8'h00, 8'h00, 0, 2);
    drive(0, 8'h10, 8'h00, 8'h00, 8'h00, 0);
    drive(1, 8'h10, 8'h00, 8'h00, 8'h00, 0, 5);
    drive(1, 8'h10, 8'h10, 8'h10, 8'h00, 1);
    drive(1, 8'h10, 8'h10, 8'h00, 8'h00, 0, 2);

    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: actual %0d left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
